// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Converts symbolic instruction requests (kind + fields) into 32-bit MIPS
// words. The opcode table matches the one the main decoder recognises.
// Encoded words are queued in a small FIFO. They are then streamed to the
// instruction-memory write port at consecutive word addresses, starting at
// BASE_ADDR. The block is used for boot loading and for injecting test
// programs ahead of the pipelined core.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready = FIFO not full)
//   req_kind          0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6/7 illegal
//   req_rs/rt/rd      register fields
//   req_funct         R-type function field
//   req_imm           16-bit immediate / offset
//   req_target        26-bit jump target
//   wvalid/wready     imem write handshake
//   waddr, wdata      byte address and encoded word of the FIFO head
//   err_illegal       one-cycle pulse after an illegal kind is accepted
//   err_count         saturating count of accepted illegal requests
//   level             FIFO occupancy
//   idle              FIFO empty
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_kind,
    input  logic [4:0]              req_rs,
    input  logic [4:0]              req_rt,
    input  logic [4:0]              req_rd,
    input  logic [5:0]              req_funct,
    input  logic [15:0]             req_imm,
    input  logic [25:0]             req_target,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [ADDR_WIDTH-1:0]   waddr,
    output logic [31:0]             wdata,
    output logic                    err_illegal,
    output logic [7:0]              err_count,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    // Request kinds
    localparam logic [2:0] KIND_RTYPE = 3'd0;
    localparam logic [2:0] KIND_LW    = 3'd1;
    localparam logic [2:0] KIND_SW    = 3'd2;
    localparam logic [2:0] KIND_BEQ   = 3'd3;
    localparam logic [2:0] KIND_ADDI  = 3'd4;
    localparam logic [2:0] KIND_J     = 3'd5;

    // Primary opcodes shared with the decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]           mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [LVL_W-1:0]      level_reg;
    logic [ADDR_WIDTH-1:0] waddr_reg;
    logic                  err_illegal_reg;
    logic [7:0]            err_count_reg;

    // ------------------------------------------------------------------
    // Combinational encoder
    // ------------------------------------------------------------------
    logic [31:0] word_next;
    logic        kind_legal;

    always_comb begin
        word_next  = '0;
        kind_legal = 1'b1;
        case (req_kind)
            KIND_RTYPE: word_next = {OP_RTYPE, req_rs, req_rt, req_rd, 5'b00000, req_funct};
            KIND_LW:    word_next = {OP_LW,    req_rs, req_rt, req_imm};
            KIND_SW:    word_next = {OP_SW,    req_rs, req_rt, req_imm};
            KIND_BEQ:   word_next = {OP_BEQ,   req_rs, req_rt, req_imm};
            KIND_ADDI:  word_next = {OP_ADDI,  req_rs, req_rt, req_imm};
            KIND_J:     word_next = {OP_J,     req_target};
            default:    kind_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic full;
    logic empty;
    logic accept;
    logic push;
    logic pop;

    // Ready is derived from registered occupancy only. A pop in the same
    // cycle does not make room for the request, which keeps wready off
    // the req_ready path.
    assign full   = (level_reg == FULL_LEVEL);
    assign empty  = (level_reg == '0);
    assign accept = req_valid && !full;
    assign push   = accept && kind_legal;
    assign pop    = !empty && wready;

    // ------------------------------------------------------------------
    // FIFO storage (no reset: contents are meaningless while empty)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= word_next;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and write address
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            waddr_reg  <= BASE_ADDR;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                // Wraps modulo 2^ADDR_WIDTH by width truncation.
                waddr_reg  <= waddr_reg + ADDR_WIDTH'(4);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Illegal-kind reporting
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            err_illegal_reg <= 1'b0;
            err_count_reg   <= '0;
        end else begin
            err_illegal_reg <= accept && !kind_legal;
            if (accept && !kind_legal && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The head word comes straight from storage. It only changes
    // on a pop, so it stays stable while the write is stalled.
    // ------------------------------------------------------------------
    assign req_ready   = !full;
    assign wvalid      = !empty;
    assign wdata       = mem[rd_ptr_reg];
    assign waddr       = waddr_reg;
    assign err_illegal = err_illegal_reg;
    assign err_count   = err_count_reg;
    assign level       = level_reg;
    assign idle        = empty;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [5:0]  req_funct;
    logic [15:0] req_imm;
    logic [25:0] req_target;
    logic        wvalid, wready;
    logic [31:0] waddr, wdata;
    logic        err_illegal;
    logic [7:0]  err_count;
    logic [2:0]  level;
    logic        idle;

    // Second instance: high base address to exercise address wrap
    logic        req_valid2, req_ready2, wvalid2, wready2, err_illegal2, idle2;
    logic [25:0] req_target2;
    logic [31:0] waddr2, wdata2;
    logic [7:0]  err_count2;
    logic [2:0]  level2;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] m_addr;
    int          m_errc;
    bit          m_pulse;
    bit          m_known = 0;

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_funct(req_funct),
        .req_imm(req_imm), .req_target(req_target),
        .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
        .err_illegal(err_illegal), .err_count(err_count), .level(level), .idle(idle)
    );

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .BASE_ADDR(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_kind(3'd5),
        .req_rs(5'd0), .req_rt(5'd0), .req_rd(5'd0), .req_funct(6'd0),
        .req_imm(16'd0), .req_target(req_target2),
        .wvalid(wvalid2), .wready(wready2), .waddr(waddr2), .wdata(wdata2),
        .err_illegal(err_illegal2), .err_count(err_count2), .level(level2), .idle(idle2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoding taken straight from the MIPS field layout
    function automatic logic [31:0] enc(input logic [2:0] k, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn, input logic [15:0] imm,
                                        input logic [25:0] tgt);
        case (k)
            3'd0:    return {6'h00, rs, rt, rd, 5'd0, fn};
            3'd1:    return {6'h23, rs, rt, imm};
            3'd2:    return {6'h2B, rs, rt, imm};
            3'd3:    return {6'h04, rs, rt, imm};
            3'd4:    return {6'h08, rs, rt, imm};
            default: return {6'h02, tgt};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic [2:0] k, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn,
                           input logic [15:0] imm, input logic [25:0] tgt);
        req_valid = v; req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd;
        req_funct = fn; req_imm = imm; req_target = tgt;
    endtask

    task automatic set_rand(input logic v, input logic [2:0] k);
        set_req(v, k, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                16'($urandom), 26'($urandom));
    endtask

    // One clock cycle: check DUT outputs against the model, then step the model.
    // Called at the falling edge with inputs already driven.
    task automatic cyc();
        bit acc, legal, pop;
        if (m_known) begin
            chk("wvalid", 64'(wvalid), 64'(q.size() != 0));
            if (q.size() != 0) chk("wdata", 64'(wdata), 64'(q[0]));
            chk("waddr", 64'(waddr), 64'(m_addr));
            chk("req_ready", 64'(req_ready), 64'(q.size() < DEPTH));
            chk("level", 64'(level), 64'(q.size()));
            chk("idle", 64'(idle), 64'(q.size() == 0));
            chk("err_illegal", 64'(err_illegal), 64'(m_pulse));
            chk("err_count", 64'(err_count), 64'(m_errc));
        end
        acc   = req_valid && (q.size() < DEPTH);
        legal = (req_kind <= 3'd5);
        pop   = (q.size() != 0) && wready;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_addr  = 32'h0;
            m_errc  = 0;
            m_pulse = 0;
            m_known = 1;
        end else begin
            if (pop) begin
                $display("[TB] write addr=%08h data=%08h", m_addr, q[0]);
                void'(q.pop_front());
                m_addr = m_addr + 32'd4;
            end
            if (acc && legal)
                q.push_back(enc(req_kind, req_rs, req_rt, req_rd, req_funct, req_imm, req_target));
            m_pulse = acc && !legal;
            if (acc && !legal && m_errc < 255) m_errc++;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; wready = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        req_valid2 = 1'b0; wready2 = 1'b0; req_target2 = 26'h0;
        @(negedge clk);
        cyc();
        reset = 1'b0;
        cyc();
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_idle", 64'(idle), 64'd1);

        // Single R-type
        wready = 1'b1;
        set_req(1, 0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0);
        cyc();
        req_valid = 1'b0;
        chk("rtype_wvalid", 64'(wvalid), 64'd1);
        chk("rtype_wdata", 64'(wdata), 64'h0022_1820);
        chk("rtype_waddr", 64'(waddr), 64'h0);
        cyc();
        chk("rtype_level", 64'(level), 64'd0);

        // Back-to-back I/J-type sequence
        set_req(1, 1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0004, 26'h0); cyc();
        chk("lw_wdata", 64'(wdata), 64'h8C08_0004);
        set_req(1, 2, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0008, 26'h0); cyc();
        chk("sw_wdata", 64'(wdata), 64'hAC08_0008);
        set_req(1, 3, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF, 26'h0); cyc();
        chk("beq_wdata", 64'(wdata), 64'h1109_FFFF);
        set_req(1, 4, 5'd0, 5'd9, 5'd0, 6'd0, 16'h0005, 26'h0); cyc();
        chk("addi_wdata", 64'(wdata), 64'h2009_0005);
        set_req(1, 5, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10); cyc();
        chk("j_wdata", 64'(wdata), 64'h0800_0010);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("seq_waddr_end", 64'(waddr), 64'h18);

        // Full FIFO with stalled write port
        wready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_rand(1, 3'($urandom_range(0, 5)));
            cyc();
        end
        chk("full_level", 64'(level), 64'd4);
        chk("full_ready", 64'(req_ready), 64'd0);
        set_rand(1, 3'd4);
        cyc(); cyc();
        wready = 1'b1; cyc();
        chk("after_pop_level", 64'(level), 64'd3);
        wready = 1'b0; cyc();
        req_valid = 1'b0;
        chk("fifth_level", 64'(level), 64'd4);
        wready = 1'b1;
        for (int i = 0; i < 5; i++) cyc();

        // Illegal kinds and saturation
        set_rand(1, 3'd6);
        cyc();
        req_valid = 1'b0;
        chk("illegal_pulse", 64'(err_illegal), 64'd1);
        chk("illegal_count", 64'(err_count), 64'd1);
        chk("illegal_nowvalid", 64'(wvalid), 64'd0);
        cyc();
        chk("illegal_pulse_end", 64'(err_illegal), 64'd0);
        for (int i = 0; i < 300; i++) begin
            set_rand(1, 3'($urandom_range(6, 7)));
            cyc();
        end
        req_valid = 1'b0;
        cyc();
        chk("err_saturate", 64'(err_count), 64'd255);

        // Reset while words are queued and stalled
        wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_rand(1, 3'($urandom_range(0, 5)));
            cyc();
        end
        req_valid = 1'b0;
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_waddr", 64'(waddr), 64'h0);
        chk("rst_errc", 64'(err_count), 64'd0);
        set_rand(1, 3'd1); cyc();
        req_valid = 1'b0;
        chk("post_rst_waddr", 64'(waddr), 64'h0);
        chk("post_rst_wvalid", 64'(wvalid), 64'd1);
        wready = 1'b1; cyc();

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            set_rand(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
            wready = ($urandom_range(0, 2) != 0);
            reset  = ($urandom_range(0, 99) == 0);
            cyc();
        end
        reset = 1'b0; req_valid = 1'b0; wready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cyc();

        // Address wrap on the high-base instance
        req_valid2 = 1'b1; req_target2 = 26'h123;
        @(posedge clk); @(posedge clk); @(negedge clk);
        req_valid2 = 1'b0;
        chk("wrap_level", 64'(level2), 64'd2);
        chk("wrap_first_addr", 64'(waddr2), 64'hFFFF_FFFC);
        chk("wrap_first_data", 64'(wdata2), 64'h0800_0123);
        wready2 = 1'b1;
        @(negedge clk);
        chk("wrap_second_wvalid", 64'(wvalid2), 64'd1);
        chk("wrap_second_addr", 64'(waddr2), 64'h0);
        @(negedge clk);
        chk("wrap_idle", 64'(idle2), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
